// File: rtl/rv32i_types.sv
// Shared types for the RV32I core memory subsystem: L2 port arbiter states and sources.
package rv32i_types;

   localparam int unsigned LINE_BYTES = 32;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D
   } arb_state_t;

   typedef enum logic {
      SRC_I,
      SRC_D
   } arb_src_t;

endpackage

// File: rtl/l2_port_arbiter_sel.sv
// Combinational winner select for the L2 port arbiter.
// ARB_ROUND_ROBIN_EN: alternate I/D on ties using last_grant; otherwise D wins ties.
module arb_priority_sel
   import rv32i_types::*;
(
   input  logic     inst_pend,
   input  logic     data_pend,
   input  arb_src_t last_grant,
   output logic     any_pend_c,
   output arb_src_t winner_c
);

   assign any_pend_c = inst_pend | data_pend;

`ifdef ARB_ROUND_ROBIN_EN
   // On a tie, hand the port to whoever did not have it last.
   always_comb begin
      winner_c = SRC_I;
      if (data_pend && !inst_pend) begin
         winner_c = SRC_D;
      end else if (data_pend && inst_pend) begin
         winner_c = (last_grant == SRC_I) ? SRC_D : SRC_I;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      winner_c = SRC_I;
      if (data_pend) begin
         winner_c = SRC_D;
      end
   end
`endif

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the L2 line port between I-cache and D-cache miss paths; one grant at a time.
// Tie policy selected by ARB_ROUND_ROBIN_EN (see arb_priority_sel).
module l2_port_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   arb_state_t        state, state_nx;
   arb_src_t          last_grant, last_grant_nx;
   arb_src_t          winner;
   logic              any_pend;
   logic              mem_read_nx, mem_write_nx;
   logic [ADDR_W-1:0] mem_address_nx;
   logic [LINE_W-1:0] mem_wdata_nx;

   arb_priority_sel u_sel (
      .inst_pend  (i_read),
      .data_pend  (d_read | d_write),
      .last_grant (last_grant),
      .any_pend_c (any_pend),
      .winner_c   (winner)
   );

   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= SRC_I;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
      end else begin
         state       <= state_nx;
         last_grant  <= last_grant_nx;
         mem_read    <= mem_read_nx;
         mem_write   <= mem_write_nx;
         mem_address <= mem_address_nx;
         mem_wdata   <= mem_wdata_nx;
      end
   end

   // Grant in IDLE, hold the captured command while serving, release on mem_resp.
   always_comb begin
      state_nx       = state;
      last_grant_nx  = last_grant;
      mem_read_nx    = mem_read;
      mem_write_nx   = mem_write;
      mem_address_nx = mem_address;
      mem_wdata_nx   = mem_wdata;
      i_resp         = 1'b0;
      d_resp         = 1'b0;
      case (state)
         IDLE: begin
            if (any_pend) begin
               if (winner == SRC_D) begin
                  state_nx       = SERVE_D;
                  mem_read_nx    = d_read;
                  mem_write_nx   = d_write;
                  mem_address_nx = d_address;
                  mem_wdata_nx   = d_wdata;
               end else begin
                  state_nx       = SERVE_I;
                  mem_read_nx    = 1'b1;
                  mem_write_nx   = 1'b0;
                  mem_address_nx = i_address;
                  mem_wdata_nx   = '0;
               end
            end
         end
         SERVE_I: begin
            if (mem_resp) begin
               i_resp        = 1'b1;
               mem_read_nx   = 1'b0;
               mem_write_nx  = 1'b0;
               last_grant_nx = SRC_I;
               state_nx      = IDLE;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               d_resp        = 1'b1;
               mem_read_nx   = 1'b0;
               mem_write_nx  = 1'b0;
               last_grant_nx = SRC_D;
               state_nx      = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A D-side request is either a read or a write-back, never both.
   a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios plus randomized requesters/memory
// against a transaction-level model. Honors ARB_ROUND_ROBIN_EN like the design.
module tb_l2_port_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 256;

   logic              clk;
   logic              rst_n;
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;

   int checks = 0;
   int failures = 0;

   // Transaction-level model: who owns the port and which command it issued.
   bit                m_busy;
   bit                m_owner_d;
   bit                m_last_d;
   logic              m_read, m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wdata;
   int                m_lat;
   bit                i_drop, d_drop;
   bit                cmp_en;
   bit                first_is_i;

   l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_read      (i_read),
      .i_address   (i_address),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_address   (d_address),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Tie rule: D wins, or with round robin the side that did not go last.
   function automatic bit pick_d(input bit ip, input bit dp, input bit last_d);
      if (ip && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
         return !last_d;
`else
         return 1'b1;
`endif
      end
      return dp;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         m_busy = 0; m_owner_d = 0; m_last_d = 0;
         m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0;
      end else if (!m_busy) begin
         if (i_read || d_read || d_write) begin
            m_busy    = 1;
            m_owner_d = pick_d(i_read, d_read | d_write, m_last_d);
            m_lat     = $urandom_range(0, 3);
            if (m_owner_d) begin
               m_read = d_read; m_write = d_write; m_addr = d_address; m_wdata = d_wdata;
            end else begin
               m_read = 1; m_write = 0; m_addr = i_address; m_wdata = '0;
            end
         end
      end else if (mem_resp) begin
         m_busy   = 0;
         m_last_d = m_owner_d;
         m_read   = 0;
         m_write  = 0;
         if (m_owner_d) d_drop = 1; else i_drop = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      #2;
      if (cmp_en) begin
         if (!rst_n) begin
            chk("rst_mem_read", 256'(mem_read), '0);
            chk("rst_mem_write", 256'(mem_write), '0);
            chk("rst_mem_address", 256'(mem_address), '0);
            chk("rst_mem_wdata", mem_wdata, '0);
            chk("rst_i_resp", 256'(i_resp), '0);
            chk("rst_d_resp", 256'(d_resp), '0);
         end else begin
            chk("mem_read", 256'(mem_read), 256'(m_read));
            chk("mem_write", 256'(mem_write), 256'(m_write));
            chk("mem_address", 256'(mem_address), 256'(m_addr));
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("i_resp", 256'(i_resp), 256'(m_busy && !m_owner_d && mem_resp));
            chk("d_resp", 256'(d_resp), 256'(m_busy && m_owner_d && mem_resp));
            chk("i_rdata", i_rdata, mem_rdata);
            chk("d_rdata", d_rdata, mem_rdata);
         end
      end
   end

   initial begin
      rst_n = 0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
      d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;
      i_drop = 0; d_drop = 0; m_lat = 0; cmp_en = 0;
      model_step();
      cmp_en = 1;
      tick(); tick();
      #1;
      chk("reset_mem_read", 256'(mem_read), '0);
      chk("reset_i_resp", 256'(i_resp), '0);
      rst_n = 1;
      tick();

      // Lone I read.
      i_read = 1; i_address = 32'h0000_0060;
      tick(); #1;
      chk("t1_mem_read", 256'(mem_read), 256'(1'b1));
      chk("t1_mem_address", 256'(mem_address), 256'(32'h60));
      mem_resp = 1; mem_rdata = {8{32'hA5A5_A5A5}}; #1;
      chk("t1_i_resp", 256'(i_resp), 256'(1'b1));
      chk("t1_i_rdata", i_rdata, {8{32'hA5A5_A5A5}});
      chk("t1_d_resp", 256'(d_resp), '0);
      tick();
      mem_resp = 0; i_read = 0; #1;
      chk("t1_idle", 256'(mem_read), '0);
      tick();

      // D write-back with address change mid-transaction.
      d_write = 1; d_address = 32'h3FE0; d_wdata = {8{32'hDEAD_BEEF}};
      tick(); #1;
      chk("t4_mem_write", 256'(mem_write), 256'(1'b1));
      chk("t4_mem_read", 256'(mem_read), '0);
      chk("t4_mem_wdata", mem_wdata, {8{32'hDEAD_BEEF}});
      d_address = 32'h1234_5660;
      tick(); tick(); #1;
      chk("t4_addr_held", 256'(mem_address), 256'(32'h3FE0));
      mem_resp = 1; #1;
      chk("t4_d_resp", 256'(d_resp), 256'(1'b1));
      chk("t4_i_resp", 256'(i_resp), '0);
      tick();
      mem_resp = 0; d_write = 0;
      tick();

      // Simultaneous I and D reads, last grant was D.
`ifdef ARB_ROUND_ROBIN_EN
      first_is_i = 1;
`else
      first_is_i = 0;
`endif
      i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h2000;
      tick(); #1;
      chk("t2_first_addr", 256'(mem_address), first_is_i ? 256'(32'h100) : 256'(32'h2000));
      chk("t2_first_read", 256'(mem_read), 256'(1'b1));
      mem_resp = 1; #1;
      chk("t2_first_resp", 256'(first_is_i ? i_resp : d_resp), 256'(1'b1));
      tick();
      mem_resp = 0;
      if (first_is_i) i_read = 0; else d_read = 0;
      #1;
      chk("t2_turnaround", 256'(mem_read | mem_write), '0);
      tick(); #1;
      chk("t2_second_addr", 256'(mem_address), first_is_i ? 256'(32'h2000) : 256'(32'h100));
      chk("t2_second_read", 256'(mem_read), 256'(1'b1));
      mem_resp = 1;
      tick();
      mem_resp = 0; i_read = 0; d_read = 0;
      tick();

      // Spurious mem_resp while idle.
      mem_resp = 1; #1;
      chk("t6_i_resp", 256'(i_resp), '0);
      chk("t6_d_resp", 256'(d_resp), '0);
      tick();
      mem_resp = 0; #1;
      chk("t6_idle", 256'(mem_read | mem_write), '0);
      tick();

      // Reset in the middle of a D read.
      d_read = 1; d_address = 32'h4000;
      tick(); #1;
      chk("t5_granted", 256'(mem_read), 256'(1'b1));
      rst_n = 0; d_read = 0; i_read = 1; i_address = 32'h80; #1;
      chk("t5_rst_read", 256'(mem_read), '0);
      chk("t5_rst_addr", 256'(mem_address), '0);
      tick();
      rst_n = 1;
      tick(); #1;
      chk("t5_regrant_read", 256'(mem_read), 256'(1'b1));
      chk("t5_regrant_addr", 256'(mem_address), 256'(32'h80));
      mem_resp = 1;
      tick();
      mem_resp = 0; i_read = 0;
      tick();

      // Randomized requesters and memory.
      i_drop = 0; d_drop = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (i_drop) begin
            i_read = 0; i_drop = 0;
         end else if (!i_read && ($urandom % 4 == 0)) begin
            i_read = 1;
         end
         if ($urandom % 2 == 0) i_address = $urandom & 32'hFFFF_FFE0;

         if (d_drop) begin
            d_read = 0; d_write = 0; d_drop = 0;
         end else if (!d_read && !d_write && ($urandom % 4 == 0)) begin
            if ($urandom % 2 == 0) d_write = 1; else d_read = 1;
         end
         if ($urandom % 2 == 0) d_address = $urandom & 32'hFFFF_FFE0;
         if ($urandom % 2 == 0) d_wdata = rand_line();

         mem_rdata = rand_line();
         if (m_busy) begin
            if (m_lat == 0) begin
               mem_resp = 1;
            end else begin
               m_lat--;
               mem_resp = 0;
            end
         end else begin
            mem_resp = ($urandom % 8 == 0);
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2/physical-memory line port between the instruction-cache miss path and the data-cache miss path of the pipelined RV32I core.
- The I-side is read-only. The D-side issues reads and write-backs.
- A 3-state FSM grants one requester at a time and registers the downstream command.
- Responses are routed back only to the granted requester.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request; held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache write-back request
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  downstream read command
- mem_write  out  1  downstream write command
- mem_address  out  ADDR_W  downstream address
- mem_wdata  out  LINE_W  downstream write line
- mem_rdata  in  LINE_W  downstream read line
- mem_resp  in  1  downstream completion pulse

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, last_grant=I.
  - mem_read, mem_write, mem_address and mem_wdata are 0.
  - i_resp and d_resp are 0.
- States: IDLE, SERVE_I, SERVE_D. Encoding is an enum in the package.
- IDLE:
  - A requester is pending when i_read, or d_read|d_write.
  - If none is pending, stay in IDLE.
  - If only one is pending, go to its SERVE state.
  - If both are pending, D wins (see Optional Feature).
  - On the transition edge, register the command: mem_read/mem_write, mem_address and mem_wdata, copied from the winner. mem_wdata=0 for I.
  - The downstream command is therefore asserted exactly 1 cycle after the request is first seen.
- SERVE_x:
  - Hold the registered command constant; later requester input changes are ignored.
  - When mem_resp=1:
    - x_resp=mem_resp combinationally, and x_rdata=mem_rdata.
    - On that edge, clear mem_read and mem_write, set last_grant=x, and go to IDLE.
  - The non-granted x_resp is always 0.
  - i_rdata and d_rdata are always the mem_rdata wire. Only the resp pulses are gated.
- Requesters drop their request the cycle after their resp. IDLE therefore always spends ≥1 cycle, so a stale request is never re-granted.
- Handshake checks:
  - d_read & d_write simultaneously is illegal. Assert in simulation.
  - mem_resp while in IDLE is ignored and produces no resp.
- Turnaround: back-to-back transactions have 1 idle cycle between mem_resp and the next mem_read/mem_write assertion.
- Reset mid-transaction returns to IDLE immediately and the command is dropped. The downstream memory is reset by the same rst_n.
- No combinational path from requester inputs to mem_* outputs.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, grant the requester that is not last_grant, so I and D alternate under contention.
- Undefined: fixed priority, D always wins ties. In this case last_grant is still maintained but is unused.

Decomposition:
- rv32i_types (shared package) gets:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}
  - arb_src_t enum {SRC_I, SRC_D}
  - localparam LINE_BYTES=32
- One sub-module: arb_priority_sel. It is purely combinational: it takes the pending bits and last_grant and returns the winner, and contains the ARB_ROUND_ROBIN_EN ifdef. The FSM and command registers remain in l2_port_arbiter.

Test Plan:
1. Lone I read: i_read=1, i_address=0x0000_0060. Expect mem_read=1 and mem_address=0x60 next cycle. mem_resp with mem_rdata=0xA5…A5 → i_resp=1 with i_rdata=0xA5…A5, d_resp=0. Then back to IDLE.
2. Simultaneous I read 0x100 and D read 0x2000, macro off → D granted first (mem_address=0x2000). After d_resp, one idle cycle, then I granted with mem_address=0x100.
3. Same stimulus with ARB_ROUND_ROBIN_EN, last_grant=D from the previous transaction → I granted first, then D.
4. D write-back: d_write=1, d_address=0x3FE0, d_wdata=0xDEADBEEF repeated. Expect mem_write=1 and matching mem_wdata. Change d_address mid-transaction → mem_address stays 0x3FE0 until mem_resp.
5. Reset mid-SERVE_D: pull rst_n low for 1 cycle → all outputs 0 asynchronously. After release, FSM is in IDLE and a pending i_read is granted next cycle.
6. Spurious mem_resp in IDLE → no i_resp or d_resp, state unchanged.
